// File: rtl/rfphoenix_branch_sched_pkg.sv
// Shared types for the branch scheduler slice.
//   value_t            : 32-bit operand value (integer or IEEE-754 single).
//   instruction_t      : opcode plus the br.cnd condition field.
//   br_sched_entry_t   : S1 pipe entry {v, thread, ir, a, b, pred}.
//   br_result_entry_t  : S2 pipe entry {v, thread, taken, pred}.
package rfphoenix_branch_sched_pkg;

  // Thread tag storage width; large enough for up to 8 slots.
  localparam int THR_MAX_W = 3;

  localparam logic [6:0] OP_BCC  = 7'h28;
  localparam logic [6:0] OP_FBCC = 7'h29;

  typedef logic [31:0] value_t;

  typedef enum logic [2:0] {
    CND_LT  = 3'd0,
    CND_GE  = 3'd1,
    CND_LE  = 3'd2,
    CND_GT  = 3'd3,
    CND_NV4 = 3'd4,
    CND_NV5 = 3'd5,
    CND_EQ  = 3'd6,
    CND_NE  = 3'd7
  } br_cnd_e;

  typedef struct packed {
    br_cnd_e    cnd;
    logic [6:0] opcode;
  } instruction_t;

  localparam int IR_W = $bits(instruction_t);

  typedef struct packed {
    logic                 v;
    logic [THR_MAX_W-1:0] thread;
    instruction_t         ir;
    value_t               a;
    value_t               b;
    logic                 pred;
  } br_sched_entry_t;

  typedef struct packed {
    logic                 v;
    logic [THR_MAX_W-1:0] thread;
    logic                 taken;
    logic                 pred;
  } br_result_entry_t;

  // Resolve a condition code from "less than" and "equal" flags.
  function automatic logic cnd_resolve(input br_cnd_e cnd, input logic lt, input logic eq);
    logic r;
    r = 1'b0;
    case (cnd)
      CND_LT: r = lt;
      CND_GE: r = !lt;
      CND_LE: r = lt | eq;
      CND_GT: r = !(lt | eq);
      CND_EQ: r = eq;
      CND_NE: r = !eq;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rfphoenix_branch_sched_eval.sv
// Branch-condition evaluator (purely combinational).
//   ir    : instruction (opcode + cnd)
//   a, b  : operands
//   taken : evaluated condition; 0 for non-branch opcodes
module rfphoenix_branch_sched_eval
  import rfphoenix_branch_sched_pkg::*;
(
  input  logic [IR_W-1:0] ir,
  input  logic [31:0]     a,
  input  logic [31:0]     b,
  output logic            taken
);

  instruction_t ir_s;
  logic         lt_i, eq_i;
  logic         a_nan, b_nan, both_zero, lt_f, eq_f;
  logic [31:0]  key_a, key_b;

  assign ir_s = instruction_t'(ir);

  always_comb begin
    lt_i = $signed(a) < $signed(b);
    eq_i = (a == b);

    a_nan = (a[30:23] == 8'hFF) && (a[22:0] != '0);
    b_nan = (b[30:23] == 8'hFF) && (b[22:0] != '0);
    both_zero = (a[30:0] == '0) && (b[30:0] == '0);
    // Map sign-magnitude floats onto an unsigned-monotonic key so a plain
    // magnitude compare orders them; +0/-0 are treated as equal separately.
    key_a = a[31] ? ~a : {1'b1, a[30:0]};
    key_b = b[31] ? ~b : {1'b1, b[30:0]};
    lt_f  = !both_zero && (key_a < key_b);
    eq_f  = both_zero || (a == b);

    taken = 1'b0;
    if (ir_s.opcode == OP_BCC) begin
      taken = cnd_resolve(ir_s.cnd, lt_i, eq_i);
    end else if (ir_s.opcode == OP_FBCC) begin
      // Unordered operands satisfy only "not equal".
      if (a_nan || b_nan) taken = (ir_s.cnd == CND_NE);
      else                taken = cnd_resolve(ir_s.cnd, lt_f, eq_f);
    end
  end

endmodule

// File: rtl/rfphoenix_branch_sched.sv
// Round-robin scheduler sharing one branch evaluator among NTHR thread slots.
// S1 registers the granted request's operands; S2 registers the result.
//   clk_i, rst_ni          : clock, async active-low reset
//   req_valid_i/ready_o    : per-slot handshake (ready is one-hot or zero)
//   req_ir_i/a_i/b_i/pred_i: per-slot branch, operands, predicted direction
//   flush_i                : per-thread kill of in-flight and granting work
//   res_valid_o/ready_i    : result handshake
//   res_thread_o/taken_o/mispredict_o : result fields
//   mispred_cnt_o          : saturating count of delivered mispredicts
module rfphoenix_branch_sched
  import rfphoenix_branch_sched_pkg::*;
#(
  parameter int NTHR = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NTHR-1:0]      req_valid_i,
  output logic [NTHR-1:0]      req_ready_o,
  input  logic [NTHR*IR_W-1:0] req_ir_i,
  input  logic [NTHR*32-1:0]   req_a_i,
  input  logic [NTHR*32-1:0]   req_b_i,
  input  logic [NTHR-1:0]      req_pred_i,
  input  logic [NTHR-1:0]      flush_i,
  output logic                 res_valid_o,
  input  logic                 res_ready_i,
  output logic [$clog2(NTHR)-1:0] res_thread_o,
  output logic                 res_taken_o,
  output logic                 res_mispredict_o,
  output logic [31:0]          mispred_cnt_o
);

  localparam int TW = $clog2(NTHR);

  br_sched_entry_t  s1_q;
  br_result_entry_t s2_q;
  logic [TW-1:0]    rr_ptr_q;
  logic [31:0]      mispred_cnt_q;

  logic [(1<<THR_MAX_W)-1:0] flush_pad;
  logic s1_kill, s2_kill, adv1, adv2;
  logic [TW:0]   pick;
  logic          grant_vld;
  logic [TW-1:0] grant_idx;
  logic          s1_taken;

  // First eligible slot at or above ptr, wrapping; returns {found, index}.
  // Scanning downward lets the closest slot to ptr be the last assignment.
  function automatic logic [TW:0] rr_pick(input logic [NTHR-1:0] elig, input logic [TW-1:0] ptr);
    logic [TW:0]   sel;
    logic [TW-1:0] idx;
    sel = '0;
    for (int i = NTHR - 1; i >= 0; i--) begin
      idx = TW'((int'(ptr) + i) % NTHR);
      if (elig[idx]) sel = {1'b1, idx};
    end
    return sel;
  endfunction

  always_comb begin
    flush_pad = '0;
    flush_pad[NTHR-1:0] = flush_i;
  end

  assign s1_kill = s1_q.v & flush_pad[s1_q.thread];
  assign s2_kill = s2_q.v & flush_pad[s2_q.thread];
  assign adv2    = !s2_q.v | res_ready_i;
  assign adv1    = !s1_q.v | adv2;

  assign pick      = rr_pick(req_valid_i & ~flush_i, rr_ptr_q);
  assign grant_vld = rst_ni & adv1 & pick[TW];
  assign grant_idx = pick[TW-1:0];

  always_comb begin
    req_ready_o = '0;
    for (int i = 0; i < NTHR; i++) begin
      req_ready_o[i] = grant_vld && (grant_idx == TW'(i));
    end
  end

  rfphoenix_branch_sched_eval u_eval (
    .ir    (s1_q.ir),
    .a     (s1_q.a),
    .b     (s1_q.b),
    .taken (s1_taken)
  );

  // S1: capture on grant, empty on advance without grant, flush overrides hold.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q <= '0;
    end else if (adv1) begin
      if (grant_vld) begin
        s1_q.v      <= 1'b1;
        s1_q.thread <= THR_MAX_W'(grant_idx);
        s1_q.ir     <= instruction_t'(req_ir_i[grant_idx*IR_W +: IR_W]);
        s1_q.a      <= req_a_i[grant_idx*32 +: 32];
        s1_q.b      <= req_b_i[grant_idx*32 +: 32];
        s1_q.pred   <= req_pred_i[grant_idx];
      end else begin
        s1_q.v <= 1'b0;
      end
    end else if (s1_kill) begin
      s1_q.v <= 1'b0;
    end
  end

  // S2: a flushed S1 entry moves in as a bubble.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s2_q <= '0;
    end else if (adv2) begin
      if (s1_q.v) begin
        s2_q.v      <= !s1_kill;
        s2_q.thread <= s1_q.thread;
        s2_q.taken  <= s1_taken;
        s2_q.pred   <= s1_q.pred;
      end else begin
        s2_q.v <= 1'b0;
      end
    end else if (s2_kill) begin
      s2_q.v <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q <= '0;
    end else if (grant_vld) begin
      rr_ptr_q <= (grant_idx == TW'(NTHR - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  assign res_valid_o      = s2_q.v & !flush_pad[s2_q.thread];
  assign res_thread_o     = s2_q.thread[TW-1:0];
  assign res_taken_o      = s2_q.taken;
  assign res_mispredict_o = s2_q.taken ^ s2_q.pred;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mispred_cnt_q <= '0;
    end else if (res_valid_o && res_ready_i && res_mispredict_o && (mispred_cnt_q != '1)) begin
      mispred_cnt_q <= mispred_cnt_q + 32'd1;
    end
  end

  assign mispred_cnt_o = mispred_cnt_q;

endmodule

// File: tb/tb_rfphoenix_branch_sched.sv
// Self-checking bench for rfphoenix_branch_sched: directed scenarios plus a
// randomized run against a cycle-level reference model of the scheduler.
module tb_rfphoenix_branch_sched;
  import rfphoenix_branch_sched_pkg::*;

  localparam int N   = 4;
  localparam int IRW = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]     req_valid = '0, req_ready, req_pred = '0, flush = '0;
  logic [N*IRW-1:0] req_ir = '0;
  logic [N*32-1:0]  req_a = '0, req_b = '0;
  logic             res_ready = 1'b0, res_valid, res_taken, res_mispredict;
  logic [1:0]       res_thread;
  logic [31:0]      cnt;

  rfphoenix_branch_sched #(.NTHR(N)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_ir_i(req_ir), .req_a_i(req_a), .req_b_i(req_b), .req_pred_i(req_pred),
    .flush_i(flush),
    .res_valid_o(res_valid), .res_ready_i(res_ready),
    .res_thread_o(res_thread), .res_taken_o(res_taken),
    .res_mispredict_o(res_mispredict), .mispred_cnt_o(cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: one optional entry waiting for its result slot
  // and one optional result on offer; taken is computed at acceptance time.
  bit          m_s1_v, m_s2_v, m_s1_tk, m_s1_pr, m_s2_tk, m_s2_pr;
  int          m_s1_thr, m_s2_thr, m_ptr;
  logic [31:0] m_cnt;
  bit          n_s1_v, n_s2_v, n_s1_tk, n_s1_pr, n_s2_tk, n_s2_pr;
  int          n_s1_thr, n_s2_thr, n_ptr;
  logic [31:0] n_cnt;
  bit          e_valid;
  logic [N-1:0] e_ready;

  function automatic real f2r(input logic [31:0] x);
    real m, r;
    int  e;
    m = real'(x[22:0]);
    e = int'(x[30:23]);
    if (e == 255)    r = 1.0e300;
    else if (e == 0) r = m * (2.0 ** (-149.0));
    else             r = (m + 8388608.0) * (2.0 ** real'(e - 150));
    return x[31] ? -r : r;
  endfunction

  function automatic bit rel(input int c, input real x, input real y);
    case (c)
      0: return x < y;
      1: return x >= y;
      2: return x <= y;
      3: return x > y;
      6: return x == y;
      7: return x != y;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit ref_taken(input logic [IRW-1:0] ir, input logic [31:0] a, input logic [31:0] b);
    int c;
    c = int'(ir[9:7]);
    if (ir[6:0] == OP_BCC) return rel(c, real'($signed(a)), real'($signed(b)));
    if (ir[6:0] == OP_FBCC) begin
      if ((a[30:23] == 8'hFF && a[22:0] != 0) || (b[30:23] == 8'hFF && b[22:0] != 0)) return c == 7;
      return rel(c, f2r(a), f2r(b));
    end
    return 1'b0;
  endfunction

  task automatic model_clear();
    m_s1_v = 0; m_s2_v = 0; m_ptr = 0; m_cnt = '0;
    m_s1_thr = 0; m_s2_thr = 0; m_s1_tk = 0; m_s1_pr = 0; m_s2_tk = 0; m_s2_pr = 0;
  endtask

  // Expected outputs for the current inputs, and next model state.
  task automatic model_eval();
    bit a1, a2;
    int g;
    e_valid = m_s2_v && !flush[m_s2_thr];
    a2 = !m_s2_v || res_ready;
    a1 = !m_s1_v || a2;
    g = -1;
    if (a1) begin
      for (int i = 0; i < N; i++) begin
        int t;
        t = (m_ptr + i) % N;
        if (g < 0 && req_valid[t] && !flush[t]) g = t;
      end
    end
    e_ready = (g >= 0) ? (N'(1) << g) : '0;
    n_cnt = m_cnt;
    if (e_valid && res_ready && (m_s2_tk != m_s2_pr) && m_cnt != 32'hFFFFFFFF) n_cnt = m_cnt + 1;
    if (a2) begin
      n_s2_v = m_s1_v && !flush[m_s1_thr];
      n_s2_thr = m_s1_thr; n_s2_tk = m_s1_tk; n_s2_pr = m_s1_pr;
    end else begin
      n_s2_v = m_s2_v && !flush[m_s2_thr];
      n_s2_thr = m_s2_thr; n_s2_tk = m_s2_tk; n_s2_pr = m_s2_pr;
    end
    if (a1) begin
      n_s1_v = (g >= 0);
      n_s1_thr = g;
      n_s1_tk = (g >= 0) ? ref_taken(req_ir[g*IRW +: IRW], req_a[g*32 +: 32], req_b[g*32 +: 32]) : 1'b0;
      n_s1_pr = (g >= 0) ? req_pred[g] : 1'b0;
    end else begin
      n_s1_v = m_s1_v && !flush[m_s1_thr];
      n_s1_thr = m_s1_thr; n_s1_tk = m_s1_tk; n_s1_pr = m_s1_pr;
    end
    n_ptr = (g >= 0) ? (g + 1) % N : m_ptr;
  endtask

  task automatic advance();
    @(posedge clk);
    m_s1_v = n_s1_v; m_s1_thr = n_s1_thr; m_s1_tk = n_s1_tk; m_s1_pr = n_s1_pr;
    m_s2_v = n_s2_v; m_s2_thr = n_s2_thr; m_s2_tk = n_s2_tk; m_s2_pr = n_s2_pr;
    m_ptr = n_ptr; m_cnt = n_cnt;
    @(negedge clk);
  endtask

  task automatic set_req(input int t, input logic [6:0] op, input logic [2:0] c,
                         input logic [31:0] a, input logic [31:0] b, input logic p);
    req_ir[t*IRW +: IRW] = {c, op};
    req_a[t*32 +: 32] = a;
    req_b[t*32 +: 32] = b;
    req_pred[t] = p;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req_valid = '0; flush = '0; res_ready = 1'b0;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    req_valid = '1;
    #1;
    n_tests++; if (req_ready !== 4'b0) begin n_fail++; $display("FAIL reset_ready got=%b want=0000", req_ready); end
    n_tests++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b want=0", res_valid); end
    n_tests++; if ({res_thread, res_taken, res_mispredict} !== 4'b0) begin n_fail++; $display("FAIL reset_fields got=%b want=0000", {res_thread, res_taken, res_mispredict}); end
    n_tests++; if (cnt !== 32'd0) begin n_fail++; $display("FAIL reset_cnt got=%h want=0", cnt); end
    req_valid = '0;
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    res_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (c == 0) begin set_req(2, OP_BCC, 3'd0, 32'hFFFFFFFB, 32'd3, 1'b0); req_valid = 4'b0100; end
      else req_valid = '0;
      #1 model_eval();
      if (c == 0) begin
        n_tests++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL single_grant got=%b want=0100", req_ready); end
      end
      if (c == 1) begin
        n_tests++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL single_early got=%b want=0", res_valid); end
      end
      if (c == 2) begin
        n_tests++;
        if ({res_valid, res_thread, res_taken, res_mispredict} !== 5'b1_10_1_1) begin
          n_fail++; $display("FAIL single_result got v=%b thr=%0d tk=%b mp=%b want v=1 thr=2 tk=1 mp=1",
                             res_valid, res_thread, res_taken, res_mispredict);
        end
      end
      if (c == 3) begin
        n_tests++; if (cnt !== 32'd1 || res_valid !== 1'b0) begin n_fail++; $display("FAIL single_cnt got cnt=%0d v=%b want cnt=1 v=0", cnt, res_valid); end
      end
      advance();
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    res_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      for (int t = 0; t < N; t++) set_req(t, OP_BCC, 3'($urandom_range(0, 7)), $urandom, $urandom, 1'($urandom));
      req_valid = '1;
      #1 model_eval();
      n_tests++; if (req_ready !== (N'(1) << (c % N))) begin n_fail++; $display("FAIL rr_grant c=%0d got=%b want=%b", c, req_ready, N'(1) << (c % N)); end
      if (c >= 2) begin
        n_tests++;
        if (res_valid !== 1'b1 || res_thread !== 2'((c - 2) % N) || res_taken !== m_s2_tk) begin
          n_fail++; $display("FAIL rr_result c=%0d got v=%b thr=%0d tk=%b want v=1 thr=%0d tk=%b",
                             c, res_valid, res_thread, res_taken, (c - 2) % N, m_s2_tk);
        end
      end
      advance();
    end
    req_valid = '0;
  endtask

  task automatic test_back_pressure();
    logic [N-1:0] pending;
    int got[$];
    do_reset();
    pending = 4'b0111;
    for (int t = 0; t < 3; t++) set_req(t, OP_BCC, 3'd6, 32'd9, 32'd9, 1'b0);
    for (int c = 0; c < 11; c++) begin
      res_ready = (c >= 5);
      req_valid = pending;
      #1 model_eval();
      n_tests++; if (req_ready !== e_ready) begin n_fail++; $display("FAIL bp_ready c=%0d got=%b want=%b", c, req_ready, e_ready); end
      if (c >= 2 && c < 5) begin
        n_tests++; if (req_ready !== 4'b0 || res_valid !== 1'b1 || res_thread !== 2'd0) begin
          n_fail++; $display("FAIL bp_stall c=%0d got rdy=%b v=%b thr=%0d want rdy=0000 v=1 thr=0", c, req_ready, res_valid, res_thread);
        end
      end
      if (res_valid && res_ready) got.push_back(int'(res_thread));
      pending = pending & ~req_ready;
      advance();
    end
    n_tests++; if (got.size() != 3) begin n_fail++; $display("FAIL bp_count got=%0d want=3", got.size()); end
    for (int i = 0; i < got.size() && i < 3; i++) begin
      n_tests++; if (got[i] != i) begin n_fail++; $display("FAIL bp_order idx=%0d got=%0d want=%0d", i, got[i], i); end
    end
    req_valid = '0;
  endtask

  task automatic test_flush();
    do_reset();
    set_req(1, OP_BCC, 3'd4, 32'd1, 32'd2, 1'b1);
    set_req(3, OP_BCC, 3'd6, 32'd7, 32'd7, 1'b0);
    for (int c = 0; c < 6; c++) begin
      req_valid = (c < 2) ? 4'b0010 : (c == 2) ? 4'b1000 : 4'b0000;
      flush     = (c == 2) ? 4'b0010 : 4'b0000;
      res_ready = (c >= 2);
      #1 model_eval();
      if (c == 2) begin
        n_tests++; if (res_valid !== 1'b0 || req_ready !== 4'b1000) begin
          n_fail++; $display("FAIL flush_same_cycle got v=%b rdy=%b want v=0 rdy=1000", res_valid, req_ready);
        end
      end
      if (c == 3) begin
        n_tests++; if (res_valid !== 1'b0 || cnt !== 32'd0) begin
          n_fail++; $display("FAIL flush_dropped got v=%b cnt=%0d want v=0 cnt=0", res_valid, cnt);
        end
      end
      if (c == 4) begin
        n_tests++; if (res_valid !== 1'b1 || res_thread !== 2'd3 || res_taken !== 1'b1 || res_mispredict !== 1'b1) begin
          n_fail++; $display("FAIL flush_other got v=%b thr=%0d tk=%b mp=%b want v=1 thr=3 tk=1 mp=1",
                             res_valid, res_thread, res_taken, res_mispredict);
        end
      end
      if (c == 5) begin
        n_tests++; if (cnt !== 32'd1) begin n_fail++; $display("FAIL flush_cnt got=%0d want=1", cnt); end
      end
      advance();
    end
  endtask

  task automatic test_fbcc_nan();
    logic [2:0] cnds [3];
    logic       want [3];
    cnds = '{3'd7, 3'd6, 3'd0};
    want = '{1'b1, 1'b0, 1'b0};
    do_reset();
    res_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (c < 3) begin set_req(0, OP_FBCC, cnds[c], 32'h7FC00000, 32'h3F800000, 1'b0); req_valid = 4'b0001; end
      else req_valid = '0;
      #1 model_eval();
      if (c >= 2) begin
        n_tests++; if (res_valid !== 1'b1 || res_taken !== want[c-2]) begin
          n_fail++; $display("FAIL fbcc_nan cnd=%0d got v=%b tk=%b want v=1 tk=%b", cnds[c-2], res_valid, res_taken, want[c-2]);
        end
      end
      advance();
    end
  endtask

  task automatic test_random();
    logic [31:0] ftab [8];
    ftab = '{32'h00000000, 32'h80000000, 32'h3F800000, 32'hBF800000,
             32'h7F800000, 32'hFF800000, 32'h7FC00000, 32'h00000001};
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int t = 0; t < N; t++) begin
        int r;
        logic [31:0] a, b;
        r = $urandom_range(0, 9);
        if (r < 5) begin
          a = $urandom;
          b = ($urandom_range(0, 3) == 0) ? a : $urandom;
          set_req(t, OP_BCC, 3'($urandom_range(0, 7)), a, b, 1'($urandom));
        end else if (r < 9) begin
          a = ($urandom_range(0, 2) == 0) ? $urandom : ftab[$urandom_range(0, 7)];
          b = ($urandom_range(0, 2) == 0) ? $urandom : ftab[$urandom_range(0, 7)];
          set_req(t, OP_FBCC, 3'($urandom_range(0, 7)), a, b, 1'($urandom));
        end else begin
          set_req(t, 7'h05, 3'($urandom_range(0, 7)), $urandom, $urandom, 1'($urandom));
        end
        req_valid[t] = ($urandom_range(0, 2) != 0);
        flush[t]     = ($urandom_range(0, 11) == 0);
      end
      res_ready = ($urandom_range(0, 9) < 7);
      #1 model_eval();
      n_tests++; if (req_ready !== e_ready) begin n_fail++; $display("FAIL rnd_ready c=%0d got=%b want=%b", c, req_ready, e_ready); end
      n_tests++; if (res_valid !== e_valid) begin n_fail++; $display("FAIL rnd_valid c=%0d got=%b want=%b", c, res_valid, e_valid); end
      if (e_valid) begin
        n_tests++;
        if (res_thread !== 2'(m_s2_thr) || res_taken !== m_s2_tk || res_mispredict !== (m_s2_tk ^ m_s2_pr)) begin
          n_fail++; $display("FAIL rnd_result c=%0d got thr=%0d tk=%b mp=%b want thr=%0d tk=%b mp=%b",
                             c, res_thread, res_taken, res_mispredict, m_s2_thr, m_s2_tk, m_s2_tk ^ m_s2_pr);
        end
      end
      n_tests++; if (cnt !== m_cnt) begin n_fail++; $display("FAIL rnd_cnt c=%0d got=%0d want=%0d", c, cnt, m_cnt); end
      advance();
    end
    req_valid = '0; flush = '0;
  endtask

  task automatic test_saturation();
    do_reset();
    res_ready = 1'b1;
    @(negedge clk);
    force dut.mispred_cnt_q = 32'hFFFFFFFE;
    #1 release dut.mispred_cnt_q;
    m_cnt = 32'hFFFFFFFE;
    for (int c = 0; c < 5; c++) begin
      if (c < 3) begin set_req(0, OP_BCC, 3'd4, $urandom, $urandom, 1'b1); req_valid = 4'b0001; end
      else req_valid = '0;
      #1 model_eval();
      n_tests++; if (cnt !== m_cnt || res_valid !== e_valid) begin
        n_fail++; $display("FAIL sat_step c=%0d got cnt=%h v=%b want cnt=%h v=%b", c, cnt, res_valid, m_cnt, e_valid);
      end
      advance();
    end
    n_tests++; if (cnt !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL sat_final got=%h want=ffffffff", cnt); end
    // Fill the pipe, then pull reset between clock edges.
    for (int t = 0; t < N; t++) set_req(t, OP_BCC, 3'd4, 32'd0, 32'd0, 1'b1);
    req_valid = '1;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({res_valid, req_ready, res_thread, res_taken, res_mispredict} !== 9'b0 || cnt !== 32'd0) begin
      n_fail++; $display("FAIL async_reset got v=%b rdy=%b thr=%0d tk=%b mp=%b cnt=%h want all zero",
                         res_valid, req_ready, res_thread, res_taken, res_mispredict, cnt);
    end
    req_valid = '0;
    do_reset();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();
    test_reset();
    test_single();
    test_round_robin();
    test_back_pressure();
    test_flush();
    test_fbcc_nan();
    test_random();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
